// File: rtl/genshin_pkg.sv
// Shared GenshinKitchen feedback encodings: header codes, payload bit positions
// and link-state values used by the feedback receive path.
package genshin_pkg;

    localparam logic [1:0] HDR_MALFORMED = 2'b00;
    localparam logic [1:0] HDR_FEEDBACK  = 2'b01;
    localparam logic [1:0] HDR_OTHER0    = 2'b10;
    localparam logic [1:0] HDR_OTHER1    = 2'b11;

    localparam int unsigned FB_FRONT = 2;
    localparam int unsigned FB_HAND  = 3;
    localparam int unsigned FB_PROC  = 4;
    localparam int unsigned FB_MACH  = 5;

    typedef enum logic [1:0] {
        LINK_WAIT  = 2'b00,
        LINK_LIVE  = 2'b01,
        LINK_STALE = 2'b10
    } link_e;

    typedef struct packed {
        logic machine;
        logic processing;
        logic hand;
        logic front;
    } fb_flags_t;

    typedef enum logic [1:0] {
        BYTE_FEEDBACK,
        BYTE_OTHER,
        BYTE_MALFORMED
    } byte_class_e;

    // Pull the four status flags out of a feedback byte.
    function automatic fb_flags_t fb_decode(input logic [7:0] b);
        fb_flags_t f;
        f.front      = b[FB_FRONT];
        f.hand       = b[FB_HAND];
        f.processing = b[FB_PROC];
        f.machine    = b[FB_MACH];
        return f;
    endfunction

    // Feedback frames need the two top bits clear; other traffic is not an error.
    function automatic byte_class_e classify(input logic [7:0] b);
        byte_class_e c;
        c = BYTE_MALFORMED;
        case (b[1:0])
            HDR_FEEDBACK:  c = (b[7:6] == 2'b00) ? BYTE_FEEDBACK : BYTE_MALFORMED;
            HDR_OTHER0,
            HDR_OTHER1:    c = BYTE_OTHER;
            HDR_MALFORMED: c = BYTE_MALFORMED;
            default:       c = BYTE_MALFORMED;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/link_watchdog.sv
// Link liveness FSM: waits for the first feedback frame, then declares the link
// stale after TIMEOUT_MS millisecond ticks without one.
module link_watchdog
    import genshin_pkg::*;
#(
    parameter int unsigned TIMEOUT_MS = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_ok,
    input  logic       ms_tick,
    input  logic       hold,
    output logic [1:0] link_state
);

    localparam int unsigned TO_W = 16;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_MS);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_MS - 1);

    link_e           state;
    logic [TO_W-1:0] to_cnt;
    logic            live_frame;
    logic            live_tick;

    // A frame beats a coincident tick; nothing counts while a script is loading.
    always_comb begin
        live_frame = frame_ok & ~hold;
        live_tick  = ms_tick & ~hold & ~frame_ok;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= LINK_WAIT;
            to_cnt <= '0;
        end else begin
            case (state)
                LINK_WAIT: begin
                    if (live_frame) begin
                        state  <= LINK_LIVE;
                        to_cnt <= '0;
                    end
                end
                LINK_LIVE: begin
                    if (live_frame) begin
                        to_cnt <= '0;
                    end else if (live_tick) begin
                        if (to_cnt >= TO_LAST) begin
                            to_cnt <= TO_LIMIT;
                            state  <= LINK_STALE;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                end
                LINK_STALE: begin
                    if (live_frame) begin
                        state  <= LINK_LIVE;
                        to_cnt <= '0;
                    end
                end
                default: begin
                    state  <= LINK_WAIT;
                    to_cnt <= '0;
                end
            endcase
        end
    end

    assign link_state = state;

endmodule

// File: rtl/feedback_rx_decoder.sv
// Decodes GenshinKitchen feedback bytes from the UART receiver into confirmed
// player/machine status flags, with link liveness and error/frame counters.
module feedback_rx_decoder
    import genshin_pkg::*;
#(
    parameter int unsigned CONFIRM    = 2,
    parameter int unsigned TIMEOUT_MS = 500,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             data_valid,
    input  logic [7:0]       data_receive,
    input  logic             script_mode,
    input  logic             ms_tick,
    output logic             sig_front,
    output logic             sig_hand,
    output logic             sig_processing,
    output logic             sig_machine,
    output logic             sig_update,
    output logic [1:0]       link_state,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      frame_count
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned FC_W  = 16;
    localparam logic [CNT_W-1:0] CONFIRM_N = CNT_W'(CONFIRM);

    logic             valid_d;
    logic             strobe;
    byte_class_e      cls;
    logic             frame_ok;
    logic             malformed;
    fb_flags_t        payload;
    fb_flags_t        cand;
    fb_flags_t        flags;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             confirmed;

    // Rising edge of valid is the byte strobe; script loading swallows it.
    always_comb begin
        strobe    = data_valid & ~valid_d & ~script_mode;
        cls       = classify(data_receive);
        payload   = fb_decode(data_receive);
        frame_ok  = strobe && (cls == BYTE_FEEDBACK);
        malformed = strobe && (cls == BYTE_MALFORMED);
    end

    // Confirm filter: flags move only after CONFIRM identical frames in a row.
    always_comb begin
        cnt_nxt = CNT_W'(1);
        if (payload == cand) begin
            cnt_nxt = (cnt >= CONFIRM_N) ? CONFIRM_N : cnt + CNT_W'(1);
        end
        confirmed = frame_ok && (cnt_nxt == CONFIRM_N) && (payload != flags);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_d     <= 1'b0;
            cand        <= '0;
            cnt         <= '0;
            flags       <= '0;
            sig_update  <= 1'b0;
            err_count   <= '0;
            frame_count <= '0;
        end else begin
            valid_d    <= data_valid;
            sig_update <= 1'b0;
            if (frame_ok) begin
                cand        <= payload;
                cnt         <= cnt_nxt;
                frame_count <= frame_count + FC_W'(1);
            end
            if (confirmed) begin
                flags      <= payload;
                sig_update <= 1'b1;
            end
            if (malformed && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

    assign sig_front      = flags.front;
    assign sig_hand       = flags.hand;
    assign sig_processing = flags.processing;
    assign sig_machine    = flags.machine;

    link_watchdog #(
        .TIMEOUT_MS(TIMEOUT_MS)
    ) u_link_watchdog (
        .clock     (clock),
        .reset     (reset),
        .frame_ok  (frame_ok),
        .ms_tick   (ms_tick),
        .hold      (script_mode),
        .link_state(link_state)
    );

endmodule
